// File: rtl/vi_intc.sv
// ============================================================================
// Module      : vi_intc
// Description : Eight-level vectored interrupt controller for the 8080 core.
//               Synchronises device requests, prioritises them against the
//               mask and in-service state, drives intr, and supplies an RST n
//               opcode during INTA. Mask/pending/in-service/EOI are exposed
//               as I/O registers.
//               Optional feature macro: VI_EDGE_TRIG_EN (edge-latched
//               pending bits); when undefined, pending follows irq levels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vi_intc #(
    parameter int LEVELS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LEVELS-1:0] irq,
    input  logic              sync,
    input  logic [7:0]        odata,
    input  logic              rd,
    input  logic              wr_n,
    input  logic              io_sel,
    input  logic [1:0]        addr,
    output logic [7:0]        data_out,
    output logic              vec_oe,
    output logic              intr
);

    // Register select encodings
    localparam logic [1:0] C_ADDR_MASK = 2'd0;
    localparam logic [1:0] C_ADDR_PEND = 2'd1;
    localparam logic [1:0] C_ADDR_ISR  = 2'd2;

    logic [LEVELS-1:0] irq_m_q, irq_m_d;
    logic [LEVELS-1:0] irq_s_q, irq_s_d;
    logic [LEVELS-1:0] mask_q, mask_d;
    logic [LEVELS-1:0] isr_q, isr_d;
    logic              inta_cyc_q, inta_cyc_d;
    logic              vec_valid_q, vec_valid_d;
    logic [2:0]        vec_lvl_q, vec_lvl_d;
    logic              rd_q, rd_d;
    logic              wr_n_q, wr_n_d;
    logic              intr_q, intr_d;
`ifdef VI_EDGE_TRIG_EN
    logic [LEVELS-1:0] irq_p_q, irq_p_d;
    logic [LEVELS-1:0] pend_q, pend_d;
`endif

    logic [LEVELS-1:0] pend;
    logic [LEVELS-1:0] elig;
    logic [2:0]        best;
    logic [3:0]        top_isr;
    logic              req;
    logic              inta_start;
    logic              ack;
    logic              wr_pulse;
    logic              eoi;
    logic [LEVELS-1:0] eoi_clr;
    logic [LEVELS-1:0] ack_set;

`ifdef VI_EDGE_TRIG_EN
    assign pend = pend_q;
`else
    assign pend = irq_s_q;
`endif

    assign elig = pend & mask_q;

    // Lowest-index eligible request and lowest-index in-service level (8 = none)
    always_comb begin
        best    = 3'd0;
        top_isr = 4'(LEVELS);
        for (int i = LEVELS - 1; i >= 0; i--) begin
            if (elig[i]) begin
                best = 3'(i);
            end
            if (isr_q[i]) begin
                top_isr = 4'(i);
            end
        end
    end

    // Strict nesting: only a strictly higher priority than anything in service
    assign req = (|elig) && ({1'b0, best} < top_isr);

    // Cycle events: INTA status at SYNC, DBIN falling edge, one-shot I/O write
    assign inta_start = sync & odata[0];
    assign ack        = inta_cyc_q & rd_q & ~rd;
    assign wr_pulse   = io_sel & ~wr_n & wr_n_q;
    assign eoi        = wr_pulse && (addr == C_ADDR_PEND);
    assign eoi_clr    = (eoi && (|isr_q)) ? (LEVELS'(1) << top_isr[2:0]) : '0;
    assign ack_set    = (ack && vec_valid_q) ? (LEVELS'(1) << vec_lvl_q) : '0;

    // Next-state computation for every register in the block
    always_comb begin
        irq_m_d = irq;
        irq_s_d = irq_m_q;
        rd_d    = rd;
        wr_n_d  = wr_n;
        mask_d  = mask_q;
        if (wr_pulse && (addr == C_ADDR_MASK)) begin
            mask_d = odata;
        end
        // EOI uses the pre-update top level; an ack in the same cycle adds its bit
        isr_d = (isr_q & ~eoi_clr) | ack_set;
        // A repeated SYNC re-latches the vector and keeps the cycle open
        inta_cyc_d  = inta_cyc_q;
        vec_lvl_d   = vec_lvl_q;
        vec_valid_d = vec_valid_q;
        if (inta_start) begin
            inta_cyc_d  = 1'b1;
            vec_lvl_d   = best;
            vec_valid_d = req;
        end else if (ack) begin
            inta_cyc_d = 1'b0;
        end
        intr_d = req & ~inta_cyc_q;
`ifdef VI_EDGE_TRIG_EN
        irq_p_d = irq_s_q;
        // A fresh edge on the level being acknowledged takes precedence
        pend_d  = (pend_q & ~ack_set) | (irq_s_q & ~irq_p_q);
`endif
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_m_q     <= '0;
            irq_s_q     <= '0;
            mask_q      <= '0;
            isr_q       <= '0;
            inta_cyc_q  <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_lvl_q   <= 3'd0;
            rd_q        <= 1'b0;
            wr_n_q      <= 1'b1;
            intr_q      <= 1'b0;
`ifdef VI_EDGE_TRIG_EN
            irq_p_q     <= '0;
            pend_q      <= '0;
`endif
        end else begin
            irq_m_q     <= irq_m_d;
            irq_s_q     <= irq_s_d;
            mask_q      <= mask_d;
            isr_q       <= isr_d;
            inta_cyc_q  <= inta_cyc_d;
            vec_valid_q <= vec_valid_d;
            vec_lvl_q   <= vec_lvl_d;
            rd_q        <= rd_d;
            wr_n_q      <= wr_n_d;
            intr_q      <= intr_d;
`ifdef VI_EDGE_TRIG_EN
            irq_p_q     <= irq_p_d;
            pend_q      <= pend_d;
`endif
        end
    end

    // Read mux: the INTA vector overrides register reads
    always_comb begin
        data_out = 8'h00;
        if (inta_cyc_q) begin
            data_out = vec_valid_q ? {2'b11, vec_lvl_q, 3'b111} : 8'hFF;
        end else if (io_sel) begin
            case (addr)
                C_ADDR_MASK: data_out = mask_q;
                C_ADDR_PEND: data_out = pend;
                C_ADDR_ISR:  data_out = isr_q;
                default:     data_out = 8'h00;
            endcase
        end
    end

    assign vec_oe = inta_cyc_q;
    assign intr   = intr_q;

endmodule

`default_nettype wire

// File: tb/tb_vi_intc.sv
// ============================================================================
// Module      : tb_vi_intc
// Description : Self-checking bench for vi_intc: table of priority scenarios
//               plus directed sequences for nesting, mask, spurious INTA,
//               simultaneous EOI/ack and reset during INTA. Expectations
//               follow VI_EDGE_TRIG_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vi_intc;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] irq;
    logic       sync;
    logic [7:0] odata;
    logic       rd;
    logic       wr_n;
    logic       io_sel;
    logic [1:0] addr;
    logic [7:0] data_out;
    logic       vec_oe;
    logic       intr;

`ifdef VI_EDGE_TRIG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    int total = 0;
    int bad   = 0;

    vi_intc #(.LEVELS(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .irq      (irq),
        .sync     (sync),
        .odata    (odata),
        .rd       (rd),
        .wr_n     (wr_n),
        .io_sel   (io_sel),
        .addr     (addr),
        .data_out (data_out),
        .vec_oe   (vec_oe),
        .intr     (intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] irq_v;
        logic [7:0] mask_v;
        logic       exp_intr;
        logic [7:0] exp_vec;
        logic [7:0] exp_isr;
    } vec_t;

    vec_t tbl [6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%02h required=0x%02h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        irq     = 8'h00;
        sync    = 1'b0;
        odata   = 8'h00;
        rd      = 1'b0;
        wr_n    = 1'b1;
        io_sel  = 1'b0;
        addr    = 2'd0;
        tick;
        tick;
        reset_n = 1'b1;
        tick;
    endtask

    task automatic io_write(input logic [1:0] a, input logic [7:0] d);
        io_sel = 1'b1;
        addr   = a;
        odata  = d;
        wr_n   = 1'b0;
        tick;
        wr_n   = 1'b1;
        io_sel = 1'b0;
        odata  = 8'h00;
    endtask

    task automatic io_read(input logic [1:0] a, output logic [7:0] d);
        io_sel = 1'b1;
        rd     = 1'b1;
        addr   = a;
        #1;
        d      = data_out;
        rd     = 1'b0;
        io_sel = 1'b0;
        #1;
    endtask

    task automatic inta_sync;
        sync  = 1'b1;
        odata = 8'h23;
        tick;
        sync  = 1'b0;
        odata = 8'h00;
    endtask

    task automatic inta_ack;
        rd = 1'b1;
        tick;
        rd = 1'b0;
        tick;
    endtask

    initial begin
        logic [7:0] d;

        //              irq     mask    intr  vector  isr
        tbl[0] = '{8'h28, 8'hFF, 1'b1, 8'hDF, 8'h08};
        tbl[1] = '{8'h01, 8'hFF, 1'b1, 8'hC7, 8'h01};
        tbl[2] = '{8'h80, 8'hFF, 1'b1, 8'hFF, 8'h80};
        tbl[3] = '{8'h0C, 8'h08, 1'b1, 8'hDF, 8'h08};
        tbl[4] = '{8'h60, 8'hC0, 1'b1, 8'hF7, 8'h40};
        tbl[5] = '{8'h04, 8'h00, 1'b0, 8'hFF, 8'h00};

        // Reset with all requests asserted
        do_reset;
        reset_n = 1'b0;
        irq     = 8'hFF;
        tick;
        tick;
        tick;
        chk("rst_intr", {7'd0, intr}, 8'h00);
        chk("rst_vec_oe", {7'd0, vec_oe}, 8'h00);
        chk("rst_data_out", data_out, 8'h00);
        irq = 8'h00;
        tick;
        reset_n = 1'b1;
        tick;
        tick;
        tick;
        io_read(2'd0, d); chk("rst_mask", d, 8'h00);
        io_read(2'd1, d); chk("rst_pend", d, 8'h00);
        io_read(2'd2, d); chk("rst_isr", d, 8'h00);
        io_read(2'd3, d); chk("rst_reg3", d, 8'h00);

        // Table-driven priority scenarios
        for (int k = 0; k < 6; k++) begin
            do_reset;
            io_write(2'd0, tbl[k].mask_v);
            irq = tbl[k].irq_v;
            repeat (LAT - 1) tick;
            chk($sformatf("t%0d_intr_early", k), {7'd0, intr}, 8'h00);
            tick;
            chk($sformatf("t%0d_intr", k), {7'd0, intr}, {7'd0, tbl[k].exp_intr});
            io_read(2'd1, d);
            chk($sformatf("t%0d_pend", k), d, tbl[k].irq_v);
            inta_sync;
            chk($sformatf("t%0d_intr_at_sync", k), {7'd0, intr}, {7'd0, tbl[k].exp_intr});
            chk($sformatf("t%0d_vec_oe", k), {7'd0, vec_oe}, 8'h01);
            chk($sformatf("t%0d_vector", k), data_out, tbl[k].exp_vec);
            rd = 1'b1;
            tick;
            chk($sformatf("t%0d_intr_after_sync", k), {7'd0, intr}, 8'h00);
            chk($sformatf("t%0d_vec_hold", k), data_out, tbl[k].exp_vec);
            rd = 1'b0;
            tick;
            chk($sformatf("t%0d_vec_oe_off", k), {7'd0, vec_oe}, 8'h00);
            io_read(2'd2, d);
            chk($sformatf("t%0d_isr", k), d, tbl[k].exp_isr);
            irq = 8'h00;
            tick;
            tick;
            chk($sformatf("t%0d_intr_end", k), {7'd0, intr}, 8'h00);
        end

        // Nesting and EOI
        do_reset;
        io_write(2'd0, 8'hFF);
        irq = 8'h28;
        repeat (LAT) tick;
        chk("nest_intr_a", {7'd0, intr}, 8'h01);
        inta_sync;
        chk("nest_vec_a", data_out, 8'hDF);
        inta_ack;
        io_read(2'd2, d); chk("nest_isr_a", d, 8'h08);
        irq = 8'h20;
        repeat (4) tick;
        chk("nest_no_preempt", {7'd0, intr}, 8'h00);
        io_read(2'd1, d); chk("nest_pend_5", d, 8'h20);
        irq = 8'h22;
        repeat (LAT) tick;
        chk("nest_intr_b", {7'd0, intr}, 8'h01);
        inta_sync;
        chk("nest_vec_b", data_out, 8'hCF);
        inta_ack;
        io_read(2'd2, d); chk("nest_isr_b", d, 8'h0A);
        irq = 8'h20;
        tick;
        tick;
        io_write(2'd1, 8'h55);
        io_read(2'd2, d); chk("eoi1_isr", d, 8'h08);
        tick;
        chk("eoi1_intr", {7'd0, intr}, 8'h00);
        io_write(2'd1, 8'h00);
        chk("eoi2_intr_next", {7'd0, intr}, 8'h00);
        io_read(2'd2, d); chk("eoi2_isr", d, 8'h00);
        tick;
        chk("eoi2_intr", {7'd0, intr}, 8'h01);
        io_write(2'd1, 8'h00);
        io_read(2'd2, d); chk("eoi_empty_isr", d, 8'h00);

        // Masked request, then unmask
        do_reset;
        irq = 8'h04;
        repeat (LAT + 2) tick;
        chk("mask_intr_off", {7'd0, intr}, 8'h00);
        io_read(2'd1, d); chk("mask_pend", d, 8'h04);
        io_write(2'd0, 8'h04);
        chk("mask_intr_1edge", {7'd0, intr}, 8'h00);
        tick;
        chk("mask_intr_2edge", {7'd0, intr}, 8'h01);

        // Request withdrawn before INTA
        do_reset;
        io_write(2'd0, 8'hFF);
        irq = 8'h10;
        repeat (LAT) tick;
        chk("spur_intr", {7'd0, intr}, 8'h01);
        irq = 8'h00;
        repeat (3) tick;
        inta_sync;
`ifdef VI_EDGE_TRIG_EN
        chk("spur_vector", data_out, 8'hE7);
`else
        chk("spur_vector", data_out, 8'hFF);
`endif
        inta_ack;
        io_read(2'd2, d);
`ifdef VI_EDGE_TRIG_EN
        chk("spur_isr", d, 8'h10);
`else
        chk("spur_isr", d, 8'h00);
`endif

        // EOI write on the same edge as the INTA acknowledge
        do_reset;
        io_write(2'd0, 8'hFF);
        irq = 8'h40;
        repeat (LAT) tick;
        inta_sync;
        chk("sim_vec6", data_out, 8'hF7);
        inta_ack;
        io_read(2'd2, d); chk("sim_isr6", d, 8'h40);
        irq = 8'h41;
        repeat (LAT) tick;
        chk("sim_intr0", {7'd0, intr}, 8'h01);
        inta_sync;
        chk("sim_vec0", data_out, 8'hC7);
        rd = 1'b1;
        tick;
        rd     = 1'b0;
        io_sel = 1'b1;
        addr   = 2'd1;
        wr_n   = 1'b0;
        tick;
        wr_n   = 1'b1;
        io_sel = 1'b0;
        chk("sim_vec_oe_off", {7'd0, vec_oe}, 8'h00);
        io_read(2'd2, d); chk("sim_isr", d, 8'h01);

        // Reset asserted during an INTA cycle
        do_reset;
        io_write(2'd0, 8'hFF);
        irq = 8'h08;
        repeat (LAT) tick;
        inta_sync;
        chk("rstinta_vec_oe", {7'd0, vec_oe}, 8'h01);
        rd = 1'b1;
        tick;
        reset_n = 1'b0;
        #1;
        chk("rstinta_vec_oe_off", {7'd0, vec_oe}, 8'h00);
        chk("rstinta_data", data_out, 8'h00);
        rd  = 1'b0;
        irq = 8'h00;
        tick;
        reset_n = 1'b1;
        tick;
        io_read(2'd2, d); chk("rstinta_isr", d, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
